// File: rtl/fifo_csr_pkg.sv
// Shared constants and FSM state types for the FIFO control/status register block.
`default_nettype none
package fifo_csr_pkg;
  localparam logic [1:0] CSR_CTRL_A   = 2'd0;
  localparam logic [1:0] CSR_STATUS_A = 2'd1;
  localparam logic [1:0] CSR_IRQEN_A  = 2'd2;

  localparam int FLUSH_BIT = 0;
  localparam int FULL_BIT  = 0;
  localparam int EMPTY_BIT = 1;
  localparam int OVF_BIT   = 2;
  localparam int UDF_BIT   = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOT_A, W_GOT_D, W_RESP} wr_state_e;
  typedef enum logic       {R_IDLE, R_DATA} rd_state_e;
endpackage
`default_nettype wire

// File: rtl/csr_sync_2ff.sv
// Two-flop synchroniser for a single level signal, with a selectable reset value.
`default_nettype none
module csr_sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule
`default_nettype wire

// File: rtl/axi_lite_fifo_csr.sv
// AXI4-Lite subordinate for the async FIFO's CTRL/STATUS registers.
// Optional IRQ_EN register and level interrupt enabled by `define FIFO_CSR_IRQ_EN.
`default_nettype none
module axi_lite_fifo_csr #(
  parameter int   ADDR_W    = 8,
  parameter int   DATA_W    = 8,
  parameter logic FLUSH_RST = 1'b1
) (
  input  logic              axi_clk,
  input  logic              axi_rst,
  input  logic [ADDR_W-1:0] awaddr,
  input  logic              awvalid,
  output logic              awready,
  input  logic [DATA_W-1:0] wdata,
  input  logic              wvalid,
  output logic              wready,
  output logic [1:0]        bresp,
  output logic              bvalid,
  input  logic              bready,
  input  logic [ADDR_W-1:0] araddr,
  input  logic              arvalid,
  output logic              arready,
  output logic [DATA_W-1:0] rdata,
  output logic [1:0]        rresp,
  output logic              rvalid,
  input  logic              rready,
  input  logic              fifo_full_async,
  input  logic              fifo_empty_async,
  input  logic              ovf_pulse,
  input  logic              udf_pulse,
  output logic              flush,
  output logic              irq
);
  import fifo_csr_pkg::*;

`ifdef FIFO_CSR_IRQ_EN
  localparam logic IRQ_MAP = 1'b1;
`else
  localparam logic IRQ_MAP = 1'b0;
`endif

  // Full address compare: any non-zero upper bit makes the access unmapped.
  function automatic logic is_mapped(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(CSR_CTRL_A)) || (a == ADDR_W'(CSR_STATUS_A)) ||
           (IRQ_MAP && (a == ADDR_W'(CSR_IRQEN_A)));
  endfunction

  wr_state_e         wst_q, wst_d;
  rd_state_e         rst_q, rst_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d, wr_addr;
  logic [DATA_W-1:0] wdata_q, wdata_d, wr_data;
  logic [DATA_W-1:0] rdata_q, rdata_d, rd_val;
  logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
  logic              wr_en, wr_ctrl, wr_sts;
  logic              flush_q, ovf_q, udf_q;
  logic              full_s, empty_s;
  logic [1:0]        ie_q;

  csr_sync_2ff #(.RST_VAL(1'b0)) u_sync_full (
    .clk(axi_clk), .rst(axi_rst), .d_i(fifo_full_async), .q_o(full_s));
  csr_sync_2ff #(.RST_VAL(1'b1)) u_sync_empty (
    .clk(axi_clk), .rst(axi_rst), .d_i(fifo_empty_async), .q_o(empty_s));

  // Commit happens on the edge that completes the second of AW/W, using the live channel value.
  always_comb begin
    wst_d    = wst_q;
    awaddr_d = awaddr_q;
    wdata_d  = wdata_q;
    bresp_d  = bresp_q;
    awready  = 1'b0;
    wready   = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = awaddr_q;
    wr_data  = wdata_q;
    case (wst_q)
      W_IDLE: begin
        awready = 1'b1;
        wready  = 1'b1;
        wr_addr = awaddr;
        wr_data = wdata;
        if (awvalid && wvalid) begin
          wr_en = 1'b1;
        end else if (awvalid) begin
          awaddr_d = awaddr;
          wst_d    = W_GOT_A;
        end else if (wvalid) begin
          wdata_d = wdata;
          wst_d   = W_GOT_D;
        end
      end
      W_GOT_A: begin
        wready  = 1'b1;
        wr_data = wdata;
        wr_en   = wvalid;
      end
      W_GOT_D: begin
        awready = 1'b1;
        wr_addr = awaddr;
        wr_en   = awvalid;
      end
      W_RESP: begin
        if (bready) wst_d = W_IDLE;
      end
      default: wst_d = W_IDLE;
    endcase
    if (wr_en) begin
      wst_d   = W_RESP;
      bresp_d = is_mapped(wr_addr) ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign wr_ctrl = wr_en && (wr_addr == ADDR_W'(CSR_CTRL_A));
  assign wr_sts  = wr_en && (wr_addr == ADDR_W'(CSR_STATUS_A));

  always_comb begin
    rd_val = '0;
    if (araddr == ADDR_W'(CSR_CTRL_A)) begin
      rd_val[FLUSH_BIT] = flush_q;
    end else if (araddr == ADDR_W'(CSR_STATUS_A)) begin
      rd_val[FULL_BIT]  = full_s;
      rd_val[EMPTY_BIT] = empty_s;
      rd_val[OVF_BIT]   = ovf_q;
      rd_val[UDF_BIT]   = udf_q;
    end else if (IRQ_MAP && (araddr == ADDR_W'(CSR_IRQEN_A))) begin
      rd_val[UDF_BIT:OVF_BIT] = ie_q;
    end
  end

  always_comb begin
    rst_d   = rst_q;
    rdata_d = rdata_q;
    rresp_d = rresp_q;
    arready = (rst_q == R_IDLE);
    case (rst_q)
      R_IDLE: if (arvalid) begin
        rdata_d = rd_val;
        rresp_d = is_mapped(araddr) ? RESP_OKAY : RESP_SLVERR;
        rst_d   = R_DATA;
      end
      R_DATA: if (rready) rst_d = R_IDLE;
      default: rst_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      wst_q    <= W_IDLE;
      rst_q    <= R_IDLE;
      awaddr_q <= '0;
      wdata_q  <= '0;
      bresp_q  <= RESP_OKAY;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
      flush_q  <= FLUSH_RST;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wst_q    <= wst_d;
      rst_q    <= rst_d;
      awaddr_q <= awaddr_d;
      wdata_q  <= wdata_d;
      bresp_q  <= bresp_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      if (wr_ctrl) flush_q <= |(wr_data & (DATA_W'(1) << FLUSH_BIT));
      // A set pulse overrides a simultaneous W1C clear.
      ovf_q <= ovf_pulse | (ovf_q & ~(wr_sts & |(wr_data & (DATA_W'(1) << OVF_BIT))));
      udf_q <= udf_pulse | (udf_q & ~(wr_sts & |(wr_data & (DATA_W'(1) << UDF_BIT))));
    end
  end

`ifdef FIFO_CSR_IRQ_EN
  logic irq_q;
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      ie_q  <= 2'b00;
      irq_q <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == ADDR_W'(CSR_IRQEN_A)))
        ie_q <= {|(wr_data & (DATA_W'(1) << UDF_BIT)), |(wr_data & (DATA_W'(1) << OVF_BIT))};
      irq_q <= |({udf_q, ovf_q} & ie_q);
    end
  end
  assign irq = irq_q;
`else
  assign ie_q = 2'b00;
  assign irq  = 1'b0;
`endif

  assign bvalid = (wst_q == W_RESP);
  assign bresp  = bresp_q;
  assign rvalid = (rst_q == R_DATA);
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign flush  = flush_q;
endmodule
`default_nettype wire

// File: tb/tb_axi_lite_fifo_csr.sv
// Directed self-checking bench for axi_lite_fifo_csr (IRQ checks only when FIFO_CSR_IRQ_EN is defined).
`timescale 1ns/1ps
`default_nettype none
module tb_axi_lite_fifo_csr;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic       awvalid = 0, awready, wvalid = 0, wready, bvalid, bready = 0;
  logic       arvalid = 0, arready, rvalid, rready = 0;
  logic [1:0] bresp, rresp;
  logic       full_a = 0, empty_a = 1, ovf_p = 0, udf_p = 0, flush, irq;
  int         n_chk = 0, n_fail = 0;
  logic [7:0] rd_v;
  logic [1:0] rsp_v;

  always #5 clk = ~clk;

  axi_lite_fifo_csr dut (
    .axi_clk(clk), .axi_rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
    .fifo_full_async(full_a), .fifo_empty_async(empty_a),
    .ovf_pulse(ovf_p), .udf_pulse(udf_p), .flush(flush), .irq(irq)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // mode 0: AW+W same cycle, 1: W first, 2: AW first
  task automatic wr(input logic [7:0] a, input logic [7:0] d, input int mode, output logic [1:0] resp);
    if (mode == 0) begin
      awaddr = a; wdata = d; awvalid = 1; wvalid = 1; tick(); awvalid = 0; wvalid = 0;
    end else if (mode == 1) begin
      wdata = d; wvalid = 1; tick(); wvalid = 0;
      chk("w_first_wready_low", {7'd0, wready}, 8'd0);
      chk("w_first_awready_high", {7'd0, awready}, 8'd1);
      awaddr = a; awvalid = 1; tick(); awvalid = 0;
    end else begin
      awaddr = a; awvalid = 1; tick(); awvalid = 0;
      wdata = d; wvalid = 1; tick(); wvalid = 0;
    end
    chk("bvalid_latency", {7'd0, bvalid}, 8'd1);
    resp = bresp;
    bready = 1; tick(); bready = 0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [7:0] v, output logic [1:0] resp);
    araddr = a; arvalid = 1; tick(); arvalid = 0;
    chk("rvalid_latency", {7'd0, rvalid}, 8'd1);
    v = rdata; resp = rresp;
    rready = 1; tick(); rready = 0;
  endtask

  initial begin
    // 1: reset state
    tick(); tick(); rst = 0; tick();
    chk("rst_ready", {5'd0, awready, wready, arready}, 8'h07);
    chk("rst_valid", {6'd0, bvalid, rvalid}, 8'h00);
    chk("rst_flush", {7'd0, flush}, 8'h01);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_rdata", rdata, 8'h00);
    rd(8'h00, rd_v, rsp_v); chk("rd_ctrl_rst", rd_v, 8'h01); chk("rd_ctrl_resp", {6'd0, rsp_v}, 8'h00);
    rd(8'h01, rd_v, rsp_v); chk("rd_status_rst", rd_v, 8'h02);

    // 2: CTRL write, W ahead of AW
    wr(8'h00, 8'hA4, 1, rsp_v); chk("wr_ctrl_bresp", {6'd0, rsp_v}, 8'h00);
    chk("flush_cleared", {7'd0, flush}, 8'h00);
    rd(8'h00, rd_v, rsp_v); chk("rd_ctrl_a4", rd_v, 8'h00);
    wr(8'h00, 8'h01, 2, rsp_v); chk("flush_set", {7'd0, flush}, 8'h01);

    // 3: synchronised flags and sticky overflow
    full_a = 1; empty_a = 0; tick(); tick(); tick();
    rd(8'h01, rd_v, rsp_v); chk("status_full", rd_v, 8'h01);
    ovf_p = 1; tick(); ovf_p = 0;
    rd(8'h01, rd_v, rsp_v); chk("status_ovf", rd_v, 8'h05);
    wr(8'h01, 8'h04, 0, rsp_v);
    rd(8'h01, rd_v, rsp_v); chk("status_ovf_w1c", rd_v, 8'h01);

    // 4: set pulse coincident with W1C commit
    ovf_p = 1; tick(); ovf_p = 0;
    awaddr = 8'h01; wdata = 8'h04; awvalid = 1; wvalid = 1; ovf_p = 1; tick();
    awvalid = 0; wvalid = 0; ovf_p = 0; bready = 1; tick(); bready = 0;
    rd(8'h01, rd_v, rsp_v); chk("ovf_set_wins", rd_v, 8'h05);
    wr(8'h01, 8'h04, 0, rsp_v);
    rd(8'h01, rd_v, rsp_v); chk("ovf_cleared", rd_v, 8'h01);
    // read and commit of the same register in one cycle
    awaddr = 8'h00; wdata = 8'h00; awvalid = 1; wvalid = 1; araddr = 8'h00; arvalid = 1; tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    chk("rw_same_old_value", rdata, 8'h01);
    chk("rw_same_flush", {7'd0, flush}, 8'h00);
    bready = 1; rready = 1; tick(); bready = 0; rready = 0;

    // 5: unmapped accesses and back-pressure
    awaddr = 8'h07; wdata = 8'hFF; awvalid = 1; wvalid = 1; tick(); wvalid = 0;
    for (int i = 0; i < 5; i++) begin
      awaddr = 8'h00; tick();
      chk("bhold_valid_resp", {4'd0, bvalid, awready, bresp}, 8'h0A);
      chk("bhold_wready", {7'd0, wready}, 8'h00);
    end
    awvalid = 0; bready = 1; tick(); bready = 0;
    chk("bresp_released", {7'd0, bvalid}, 8'h00);
    araddr = 8'h07; arvalid = 1; tick();
    for (int i = 0; i < 5; i++) begin
      araddr = 8'h00; tick();
      chk("rhold_data", rdata, 8'h00);
      chk("rhold_ctl", {4'd0, rvalid, arready, rresp}, 8'h0A);
    end
    arvalid = 0; rready = 1; tick(); rready = 0;
    wr(8'h40, 8'h01, 0, rsp_v); chk("upper_addr_slverr", {6'd0, rsp_v}, 8'h02);
    rd(8'h00, rd_v, rsp_v); chk("ctrl_unchanged", rd_v, 8'h00);
    rd(8'h01, rd_v, rsp_v); chk("status_unchanged", rd_v, 8'h01);

`ifdef FIFO_CSR_IRQ_EN
    // 6: interrupt path
    wr(8'h02, 8'h08, 0, rsp_v); chk("irqen_okay", {6'd0, rsp_v}, 8'h00);
    rd(8'h02, rd_v, rsp_v); chk("irqen_rd", rd_v, 8'h08);
    udf_p = 1; tick(); udf_p = 0; tick();
    chk("irq_set", {7'd0, irq}, 8'h01);
    wr(8'h01, 8'h08, 0, rsp_v); tick();
    chk("irq_clear", {7'd0, irq}, 8'h00);
`else
    wr(8'h02, 8'h0C, 0, rsp_v); chk("irqen_unmapped_b", {6'd0, rsp_v}, 8'h02);
    rd(8'h02, rd_v, rsp_v); chk("irqen_unmapped_r", {rd_v[5:0], rsp_v}, 8'h02);
    udf_p = 1; tick(); udf_p = 0; tick();
    chk("irq_tied", {7'd0, irq}, 8'h00);
`endif

    // reset in the middle of a write response
    full_a = 0; empty_a = 1;
    awaddr = 8'h00; wdata = 8'h00; awvalid = 1; wvalid = 1; tick(); awvalid = 0; wvalid = 0;
    awaddr = 8'h01; awvalid = 1; #2 rst = 1; #3 rst = 0; awvalid = 0; tick();
    chk("midrst_bvalid", {7'd0, bvalid}, 8'h00);
    chk("midrst_ready", {5'd0, awready, wready, arready}, 8'h07);
    chk("midrst_flush", {7'd0, flush}, 8'h01);
    tick(); tick();
    rd(8'h01, rd_v, rsp_v); chk("midrst_status", rd_v, 8'h02);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
